// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NUM_REQ requesters.
// Results land in a single-entry response buffer with its own valid/ready handshake.
module adder_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_x,
    input  logic [NUM_REQ*32-1:0] req_y,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout,
    input  logic                  rsp_ready
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_sum_q;
    logic            rsp_cout_q;

    logic            can_acc;
    logic            found;
    logic            accept;
    logic [ID_W-1:0] win;
    logic [ID_W:0]   cand;

    logic [31:0]     add_x;
    logic [31:0]     add_y;
    logic            add_cin;
    logic [31:0]     add_sum;
    logic            add_cout;

    // A slot opens when the buffer is empty or is being drained this cycle.
    assign can_acc = (state_q == StEmpty) | rsp_ready;

    // Search starts one past the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    // No handshake may complete while reset is held.
    assign accept = found & can_acc & rst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = accept && (win == ID_W'(i));
        end
    end

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == ID_W'(i)) begin
                add_x   = req_x[32*i +: 32];
                add_y   = req_y[32*i +: 32];
                add_cin = req_cin[i];
            end
        end
    end

    // The single shared 32-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + 33'(add_cin);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = win;
        end
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (rsp_ready && !accept) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Payload only moves on an accept, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else if (accept) begin
            rsp_id_q   <= win;
            rsp_sum_q  <= add_sum;
            rsp_cout_q <= add_cout;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with NUM_REQ=4.
module tb_adder_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_x;
    logic [NUM_REQ*32-1:0] req_y;
    logic [NUM_REQ-1:0]    req_cin;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ready;

    int checks;
    int failures;

    adder_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_cin  (req_cin),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic cin);
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_cin[i]        = cin;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [ID_W-1:0] id,
                           input logic [31:0] sum, input logic cout);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
        chk({tag, "_id"},    64'(rsp_id),    64'(id));
        chk({tag, "_sum"},   64'(rsp_sum),   64'(sum));
        chk({tag, "_cout"},  64'(rsp_cout),  64'(cout));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd10, 1'b1);

        // 1: reset with every requester valid
        req_valid = 4'b1111;
        tick();
        tick();
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk_rsp("rst", 1'b0, 2'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_first_grant", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("rst_first_rsp", 1'b1, 2'd0, 32'd11, 1'b0);
        chk("rst_full_block", 64'(req_ready), 64'h0);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("rst_drained", 64'(rsp_valid), 64'h0);

        // 2: single add with carry out from req 2
        set_ops(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_ready_gone", 64'(req_ready), 64'h0);
        chk_rsp("single", 1'b1, 2'd2, 32'd0, 1'b1);
        set_ops(2, 32'd2, 32'd10, 1'b1);
        tick();
        chk("single_drained", 64'(rsp_valid), 64'h0);

        // Re-reset so the priority pointer restarts at req 0
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // 3: round-robin with all valid, continuous drain
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("rr_ready%0d", n), 64'(req_ready), 64'(4'b0001 << (n % 4)));
            tick();
            chk_rsp($sformatf("rr%0d", n), 1'b1, 2'(n % 4), 32'(11 + (n % 4)), 1'b0);
        end

        // 4: backpressure with req 1 and req 3 competing
        req_valid = '0;
        tick();
        chk("bp_empty", 64'(rsp_valid), 64'h0);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant1", 64'(req_ready), 64'b0010);
        tick();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("bp_hold_ready%0d", n), 64'(req_ready), 64'h0);
            chk_rsp($sformatf("bp_hold%0d", n), 1'b1, 2'd1, 32'd12, 1'b0);
            set_ops(1, 32'h100 + 32'(n), 32'd10, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_drain_grant3", 64'(req_ready), 64'b1000);
        tick();
        chk_rsp("bp_refill", 1'b1, 2'd3, 32'd14, 1'b0);

        // 5: priority wrap from last_grant=3
        set_ops(1, 32'd1, 32'd10, 1'b1);
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready0", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("wrap0", 1'b1, 2'd0, 32'd11, 1'b0);
        chk("wrap_ready3", 64'(req_ready), 64'b1000);
        tick();
        chk_rsp("wrap3", 1'b1, 2'd3, 32'd14, 1'b0);

        // 6: asynchronous reset while full and stalled
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_rsp("midrst", 1'b0, 2'd0, 32'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("midrst_grant0", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("midrst_rsp", 1'b1, 2'd0, 32'd11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
